div_tick_sel: RTL and testbench

Downstream consumer of the 8-bit free-running divider count. Selects one divider tap `cnt[k]` and converts its rising edges into single-cycle clock-enable strobes (`tick`) in the system clock domain, so no logic is clocked from a divider bit. Switches taps glitch-free at run time, gates strobes with an enable, and keeps a wrapping strobe counter for monitoring.

---
 rtl/div_tick_sel_pkg.sv | 8 +
 rtl/div_tick_sel_if.sv | 18 +
 rtl/div_tick_sel_tap_edge_det.sv | 19 +
 rtl/div_tick_sel.sv | 44 ++++
 tb/tb_div_tick_sel.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/div_tick_sel_pkg.sv
// div_pkg: shared widths, FSM encoding and tap index type for div_tick_sel
package div_pkg;
  localparam int DEF_CW = 8;
  localparam int DEF_SW = 3;
  localparam int DEF_TW = 16;
  typedef enum logic {ST_RUN, ST_SWITCH} state_t;
  typedef logic [DEF_SW-1:0] tap_t;
endpackage

// File: rtl/div_tick_sel_if.sv
// div_tick_sel_if: divider count in, tap control in, strobe and status out
interface div_tick_sel_if import div_pkg::*; #(
  parameter int CW = DEF_CW,
  parameter int SW = DEF_SW,
  parameter int TW = DEF_TW
);
  logic [CW-1:0] cnt;
  logic          en;
  logic [SW-1:0] sel_in;
  logic          sel_load;
  logic          clr;
  logic          tick;
  logic [SW-1:0] sel_active;
  logic          busy;
  logic [TW-1:0] tick_cnt;
  modport master (output cnt, en, sel_in, sel_load, clr, input tick, sel_active, busy, tick_cnt);
  modport slave (input cnt, en, sel_in, sel_load, clr, output tick, sel_active, busy, tick_cnt);
endinterface

// File: rtl/div_tick_sel_tap_edge_det.sv
// tap_edge_det: rising-edge detect on the selected divider tap
module tap_edge_det #(
  parameter int CW = 8,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cnt,
  input  logic [SW-1:0] sel,
  input  logic [SW-1:0] pend,
  input  logic          load,
  output logic          e
);
  logic prev;
  // on a switch, prime prev from the new tap so the change itself is not an edge
  always_ff @(posedge clk)
    prev <= rst ? 1'b0 : load ? cnt[pend] : cnt[sel];
  assign e = cnt[sel] & ~prev;
endmodule

// File: rtl/div_tick_sel.sv
// div_tick_sel: divider tap to clock-enable strobe with glitch-free tap switching
module div_tick_sel import div_pkg::*; #(
  parameter int CW = DEF_CW,
  parameter int SW = DEF_SW,
  parameter int TW = DEF_TW
) (
  input logic          clk,
  input logic          rst,
  div_tick_sel_if.slave bus
);
  state_t        state, state_n;
  logic [SW-1:0] pend, pend_n, sel_active;
  logic          e, done, tick, req;
  logic [TW-1:0] tick_cnt;
  assign req  = bus.sel_load && (state == ST_SWITCH || bus.sel_in != sel_active);
  assign done = state == ST_SWITCH && e;
  tap_edge_det #(.CW(CW), .SW(SW)) u_edge (
    .clk(clk), .rst(rst), .cnt(bus.cnt), .sel(sel_active),
    .pend(pend_n), .load(done), .e(e)
  );
  always_comb begin
    pend_n  = req ? bus.sel_in : pend;
    state_n = state == ST_RUN ? (req ? ST_SWITCH : ST_RUN) : (e ? ST_RUN : ST_SWITCH);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      pend       <= '0;
      sel_active <= '0;
      tick       <= 1'b0;
      tick_cnt   <= '0;
    end else begin
      state      <= state_n;
      pend       <= pend_n;
      sel_active <= done ? pend_n : sel_active;
      tick       <= bus.en & e;
      tick_cnt   <= bus.clr ? '0 : tick_cnt + TW'(tick);
    end
  end
  assign bus.tick       = tick;
  assign bus.sel_active = sel_active;
  assign bus.busy       = state == ST_SWITCH;
  assign bus.tick_cnt   = tick_cnt;
endmodule

// File: tb/tb_div_tick_sel.sv
// tb_div_tick_sel: directed scenarios for tap strobes, switching, enable, counter and reset
module tb_div_tick_sel;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  div_tick_sel_if #(.CW(8), .SW(3), .TW(16)) bus ();
  div_tick_sel_if #(.CW(8), .SW(3), .TW(3)) sbus ();
  div_tick_sel #(.CW(8), .SW(3), .TW(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  div_tick_sel #(.CW(8), .SW(3), .TW(3)) dut_s (.clk(clk), .rst(rst), .bus(sbus.slave));
  assign sbus.cnt = bus.cnt;
  assign sbus.en = bus.en;
  assign sbus.sel_in = bus.sel_in;
  assign sbus.sel_load = bus.sel_load;
  assign sbus.clr = bus.clr;

  always #5 clk = ~clk;

  // divider advances just after the edge, outputs are sampled on the falling edge
  task automatic step;
    @(posedge clk);
    #1 bus.cnt = rst ? 8'd0 : bus.cnt + 8'd1;
    @(negedge clk);
  endtask

  // tick seen now means tap k rose between cnt-2 and cnt-1
  function automatic logic exp_tick(logic [7:0] c, int k);
    logic [7:0] d, m, b;
    d = c - 8'd1;
    m = (8'd2 << k) - 8'd1;
    b = 8'd1 << k;
    return (d & m) == b;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) step;
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", bus.tick); end
    checks++; if (bus.sel_active !== 3'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", bus.sel_active); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.tick_cnt !== 16'd0) begin errors++; $display("FAIL reset_tick_cnt got %0d exp 0", bus.tick_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_tap0;
    for (int i = 0; i < 12; i++) begin
      step;
      checks++;
      if (bus.tick !== exp_tick(bus.cnt, 0)) begin errors++; $display("FAIL tap0_tick cnt=%0d got %b exp %b", bus.cnt, bus.tick, exp_tick(bus.cnt, 0)); end
      if (bus.cnt == 8'd9) begin
        checks++;
        if (bus.tick_cnt !== 16'd4) begin errors++; $display("FAIL tap0_tick_cnt got %0d exp 4", bus.tick_cnt); end
      end
    end
    bus.sel_in = 3'd0; bus.sel_load = 1'b1;
    step;
    bus.sel_load = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL same_tap_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_switch;
    int n = 0;
    bus.sel_in = 3'd2; bus.sel_load = 1'b1;
    step;
    bus.sel_load = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL sw_busy_rise got %b exp 1", bus.busy); end
    while (bus.busy && n < 4) begin step; n++; end
    checks++; if (n < 1 || n > 2 || bus.busy !== 1'b0) begin errors++; $display("FAIL sw_busy_len got %0d exp 1..2", n); end
    checks++; if (bus.tick !== 1'b1) begin errors++; $display("FAIL sw_old_tick got %b exp 1", bus.tick); end
    checks++; if (bus.sel_active !== 3'd2) begin errors++; $display("FAIL sw_sel got %0d exp 2", bus.sel_active); end
    for (int i = 0; i < 24; i++) begin
      step;
      checks++;
      if (bus.tick !== exp_tick(bus.cnt, 2) || bus.busy !== 1'b0) begin errors++; $display("FAIL tap2_tick cnt=%0d got %b exp %b", bus.cnt, bus.tick, exp_tick(bus.cnt, 2)); end
    end
  endtask

  task automatic test_last_wins;
    int n = 0;
    bus.sel_in = 3'd5; bus.sel_load = 1'b1;
    step;
    bus.sel_load = 1'b0;
    while (bus.busy && n < 12) begin step; n++; end
    checks++; if (bus.sel_active !== 3'd5 || bus.busy !== 1'b0) begin errors++; $display("FAIL lw_to5 got %0d exp 5", bus.sel_active); end
    n = 0;
    do begin step; n++; end while (!bus.tick && n < 80);
    checks++; if (bus.tick !== 1'b1) begin errors++; $display("FAIL lw_tap5_tick got %b exp 1", bus.tick); end
    bus.sel_in = 3'd7; bus.sel_load = 1'b1;
    step;
    bus.sel_in = 3'd1;
    step;
    bus.sel_load = 1'b0;
    n = 0;
    while (bus.busy && n < 70) begin
      checks++;
      if (bus.tick !== exp_tick(bus.cnt, 5)) begin errors++; $display("FAIL lw_old_tick cnt=%0d got %b exp %b", bus.cnt, bus.tick, exp_tick(bus.cnt, 5)); end
      step; n++;
    end
    checks++; if (bus.busy !== 1'b0 || bus.tick !== 1'b1) begin errors++; $display("FAIL lw_done busy=%b tick=%b exp busy=0 tick=1", bus.busy, bus.tick); end
    checks++; if (bus.sel_active !== 3'd1) begin errors++; $display("FAIL lw_sel got %0d exp 1", bus.sel_active); end
    for (int i = 0; i < 20; i++) begin
      step;
      checks++;
      if (bus.tick !== exp_tick(bus.cnt, 1) || bus.busy !== 1'b0) begin errors++; $display("FAIL tap1_tick cnt=%0d got %b busy=%b exp %b", bus.cnt, bus.tick, bus.busy, exp_tick(bus.cnt, 1)); end
    end
  endtask

  task automatic test_enable;
    int n = 0;
    int seen = 0;
    logic [15:0] saved;
    bus.sel_in = 3'd3; bus.sel_load = 1'b1;
    step;
    bus.sel_load = 1'b0;
    while (bus.busy && n < 8) begin step; n++; end
    checks++; if (bus.sel_active !== 3'd3) begin errors++; $display("FAIL en_to3 got %0d exp 3", bus.sel_active); end
    bus.en = 1'b0;
    step;
    step;
    saved = bus.tick_cnt;
    for (int i = 0; i < 300; i++) begin
      step;
      checks++;
      if (bus.tick !== 1'b0 || bus.tick_cnt !== saved) begin errors++; $display("FAIL en_off tick=%b cnt=%0d exp tick=0 cnt=%0d", bus.tick, bus.tick_cnt, saved); end
    end
    bus.en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step;
      checks++;
      if (bus.tick !== exp_tick(bus.cnt, 3)) begin errors++; $display("FAIL en_on_tick cnt=%0d got %b exp %b", bus.cnt, bus.tick, exp_tick(bus.cnt, 3)); end
      seen += int'(bus.tick);
    end
    step;
    checks++; if (bus.tick_cnt !== saved + 16'(seen)) begin errors++; $display("FAIL en_on_count got %0d exp %0d", bus.tick_cnt, saved + 16'(seen)); end
  endtask

  task automatic test_tick_cnt;
    int n = 0;
    bus.sel_in = 3'd0; bus.sel_load = 1'b1;
    step;
    bus.sel_load = 1'b0;
    while (bus.busy && n < 20) begin step; n++; end
    n = 0;
    while (!bus.tick && n < 4) begin step; n++; end
    bus.clr = 1'b1;
    step;
    bus.clr = 1'b0;
    checks++; if (bus.tick_cnt !== 16'd0) begin errors++; $display("FAIL clr_vs_tick got %0d exp 0", bus.tick_cnt); end
    checks++; if (sbus.tick_cnt !== 3'd0) begin errors++; $display("FAIL clr_vs_tick_small got %0d exp 0", sbus.tick_cnt); end
    n = 0;
    while (!(sbus.tick_cnt == 3'd7 && bus.tick) && n < 40) begin step; n++; end
    step;
    checks++; if (sbus.tick_cnt !== 3'd0) begin errors++; $display("FAIL wrap_small got %0d exp 0", sbus.tick_cnt); end
    checks++; if (bus.tick_cnt !== 16'd8) begin errors++; $display("FAIL wrap_big got %0d exp 8", bus.tick_cnt); end
  endtask

  task automatic test_rst_mid_switch;
    int n = 0;
    bus.sel_in = 3'd7; bus.sel_load = 1'b1;
    step;
    bus.sel_load = 1'b0;
    while (bus.busy && n < 4) begin step; n++; end
    n = 0;
    do begin step; n++; end while (!bus.tick && n < 300);
    bus.sel_in = 3'd2; bus.sel_load = 1'b1;
    step;
    bus.sel_load = 1'b0;
    repeat (3) step;
    checks++; if (bus.busy !== 1'b1 || bus.sel_active !== 3'd7) begin errors++; $display("FAIL rst_pre busy=%b sel=%0d exp busy=1 sel=7", bus.busy, bus.sel_active); end
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    checks++; if (bus.sel_active !== 3'd0) begin errors++; $display("FAIL rst_sel got %0d exp 0", bus.sel_active); end
    checks++; if (bus.tick_cnt !== 16'd0) begin errors++; $display("FAIL rst_tick_cnt got %0d exp 0", bus.tick_cnt); end
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b exp 0", bus.tick); end
    for (int i = 0; i < 6; i++) begin
      step;
      checks++;
      if (bus.tick !== exp_tick(bus.cnt, 0) || bus.busy !== 1'b0) begin errors++; $display("FAIL post_rst_tick cnt=%0d got %b exp %b", bus.cnt, bus.tick, exp_tick(bus.cnt, 0)); end
    end
  endtask

  initial begin
    bus.cnt = 8'd0;
    bus.en = 1'b1;
    bus.sel_in = 3'd0;
    bus.sel_load = 1'b0;
    bus.clr = 1'b0;
    test_reset;
    test_tap0;
    test_switch;
    test_last_wins;
    test_enable;
    test_tick_cnt;
    test_rst_mid_switch;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
